// File: rtl/preif_fetch_gen.sv
// PRE-IF fetch-address generator: owns the fetch PC, arbitrates prioritised redirects and
// issues aligned fetch groups to the I$. Optional BTB prediction is enabled with PREIF_BTB_EN.
module preif_fetch_gen #(
  parameter int          FETCH_WIDTH = 2,
  parameter int          NUM_REDIR   = 6,
  parameter logic [31:0] RESET_PC    = 32'hBFC00000,
  parameter int          BTB_ENTRIES = 16
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      preif_wr,
  input  logic [NUM_REDIR-1:0]      redir_valid,
  input  logic [NUM_REDIR*32-1:0]   redir_target,
  output logic                      req_valid,
  output logic [31:0]               req_pc,
  output logic [FETCH_WIDTH-1:0]    req_mask,
  input  logic                      req_ready,
  output logic                      exc_adel,
  output logic                      pred_taken,
  input  logic                      bu_valid,
  input  logic [31:0]               bu_pc,
  input  logic [31:0]               bu_target
);

  localparam logic [31:0] GRP_BYTES = 32'(4 * FETCH_WIDTH);
  localparam int          SEL_W     = (NUM_REDIR > 1) ? $clog2(NUM_REDIR) : 1;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t             state_r, state_nxt_s;
  logic [31:0]        pc_r, pc_nxt_s;
  logic               pend_v_r, pend_v_nxt_s;
  logic [SEL_W-1:0]   pend_idx_r, pend_idx_nxt_s;
  logic [31:0]        pend_tgt_r, pend_tgt_nxt_s;

  logic               live_hit_s;
  logic [SEL_W-1:0]   live_idx_s;
  logic [31:0]        live_tgt_s;
  logic               redir_hit_s;
  logic [31:0]        redir_tgt_s;

  logic               aligned_s;
  logic               req_valid_s;
  logic [31:0]        slot_s;
  logic [31:0]        pc_step_s;
  logic               btb_hit_s;
  logic [31:0]        btb_tgt_s;

`ifdef PREIF_BTB_EN
  localparam int IDX_W = (BTB_ENTRIES > 1) ? $clog2(BTB_ENTRIES) : 1;
  localparam int OFS   = 2 + $clog2(FETCH_WIDTH);

  logic [BTB_ENTRIES-1:0] btb_v_r;
  logic [31:0]            btb_tag_r [BTB_ENTRIES];
  logic [31:0]            btb_tgt_r [BTB_ENTRIES];
  logic [IDX_W-1:0]       lk_idx_s, up_idx_s;

  // Direct-mapped lookup on the current PC; tags are kept as the full shifted upper bits.
  always_comb begin
    lk_idx_s  = pc_r[OFS +: IDX_W];
    up_idx_s  = bu_pc[OFS +: IDX_W];
    btb_hit_s = btb_v_r[lk_idx_s] && (btb_tag_r[lk_idx_s] == (pc_r >> (OFS + IDX_W)));
    btb_tgt_s = btb_tgt_r[lk_idx_s];
  end

  // BTB valid bits: cleared on reset, set by a branch-unit update.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      btb_v_r <= '0;
    end else if (bu_valid) begin
      btb_v_r[up_idx_s] <= 1'b1;
    end else begin
      btb_v_r <= btb_v_r;
    end
  end

  // BTB payload write; a same-cycle lookup still sees the old entry.
  always_ff @(posedge clk) begin
    if (bu_valid) begin
      btb_tag_r[up_idx_s] <= bu_pc >> (OFS + IDX_W);
      btb_tgt_r[up_idx_s] <= bu_target;
    end
  end
`else
  logic bu_unused_s;

  // No predictor in this build: never hit, update port ignored.
  always_comb begin
    btb_hit_s   = 1'b0;
    btb_tgt_s   = 32'h0000_0000;
    bu_unused_s = ^{bu_valid, bu_pc, bu_target};
  end
`endif

  // Redirect arbitration: lowest live index, then compare against the held pending redirect.
  always_comb begin
    live_hit_s = |redir_valid;
    live_idx_s = '0;
    live_tgt_s = 32'h0000_0000;
    for (int i = NUM_REDIR - 1; i >= 0; i--) begin
      live_idx_s = redir_valid[i] ? SEL_W'(i) : live_idx_s;
      live_tgt_s = redir_valid[i] ? redir_target[32*i +: 32] : live_tgt_s;
    end
    if (pend_v_r && (!live_hit_s || (pend_idx_r < live_idx_s))) begin
      redir_hit_s = 1'b1;
      redir_tgt_s = pend_tgt_r;
    end else begin
      redir_hit_s = live_hit_s;
      redir_tgt_s = live_tgt_s;
    end
  end

  // Request outputs depend only on registered state.
  always_comb begin
    aligned_s   = (pc_r[1:0] == 2'b00);
    req_valid_s = (state_r == ST_RUN) && aligned_s;
    slot_s      = (pc_r >> 2) & 32'(FETCH_WIDTH - 1);
    pc_step_s   = btb_hit_s ? btb_tgt_s : ((pc_r & ~(GRP_BYTES - 32'd1)) + GRP_BYTES);
    req_valid   = req_valid_s;
    req_pc      = pc_r;
    exc_adel    = (state_r == ST_RUN) && !aligned_s;
    pred_taken  = req_valid_s && btb_hit_s;
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      req_mask[k] = req_valid_s && (32'(k) >= slot_s);
    end
  end

  // Next-state: redirects win over sequential advance; stalls capture redirects into pend.
  always_comb begin
    state_nxt_s    = state_r;
    pc_nxt_s       = pc_r;
    pend_v_nxt_s   = pend_v_r;
    pend_idx_nxt_s = pend_idx_r;
    pend_tgt_nxt_s = pend_tgt_r;
    if (preif_wr) begin
      if (redir_hit_s) begin
        pc_nxt_s     = redir_tgt_s;
        pend_v_nxt_s = 1'b0;
        state_nxt_s  = ST_RUN;
      end else begin
        case (state_r)
          ST_BOOT: state_nxt_s = ST_RUN;
          ST_RUN: begin
            if (!aligned_s) begin
              state_nxt_s = ST_HALT;
            end else if (req_ready) begin
              pc_nxt_s = pc_step_s;
            end else begin
              pc_nxt_s = pc_r;
            end
          end
          ST_HALT: state_nxt_s = ST_HALT;
          default: state_nxt_s = ST_BOOT;
        endcase
      end
    end else begin
      if (state_r == ST_BOOT) begin
        state_nxt_s = ST_RUN;
      end else begin
        state_nxt_s = state_r;
      end
      if (live_hit_s && (!pend_v_r || (live_idx_s <= pend_idx_r))) begin
        pend_v_nxt_s   = 1'b1;
        pend_idx_nxt_s = live_idx_s;
        pend_tgt_nxt_s = live_tgt_s;
      end else begin
        pend_v_nxt_s = pend_v_r;
      end
    end
  end

  // State, PC and pending-redirect registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r    <= ST_BOOT;
      pc_r       <= RESET_PC;
      pend_v_r   <= 1'b0;
      pend_idx_r <= '0;
      pend_tgt_r <= 32'h0000_0000;
    end else begin
      state_r    <= state_nxt_s;
      pc_r       <= pc_nxt_s;
      pend_v_r   <= pend_v_nxt_s;
      pend_idx_r <= pend_idx_nxt_s;
      pend_tgt_r <= pend_tgt_nxt_s;
    end
  end

endmodule

// File: tb/tb_preif_fetch_gen.sv
// Bench for preif_fetch_gen: directed scenarios plus randomized traffic against a
// behavioural fetch model (optional BTB behaviour follows PREIF_BTB_EN).
module tb_preif_fetch_gen;

  localparam int          FW    = 2;
  localparam int          NR    = 6;
  localparam int          BTBN  = 16;
  localparam logic [31:0] RPC   = 32'hBFC00000;
`ifdef PREIF_BTB_EN
  localparam bit BTB_EN = 1'b1;
`else
  localparam bit BTB_EN = 1'b0;
`endif

  logic              clk, resetn, preif_wr, req_ready, bu_valid;
  logic [NR-1:0]     redir_valid;
  logic [NR*32-1:0]  redir_target;
  logic              req_valid, exc_adel, pred_taken;
  logic [31:0]       req_pc, bu_pc, bu_target;
  logic [FW-1:0]     req_mask;

  int total = 0;
  int bad   = 0;

  // Model state: mode 0=boot, 1=running, 2=halted after address error
  logic [31:0] m_pc;
  int          m_mode;
  bit          m_pv;
  int          m_pidx;
  logic [31:0] m_ptgt;
  bit          m_bv   [BTBN];
  logic [31:0] m_btag [BTBN];
  logic [31:0] m_btgt [BTBN];

  preif_fetch_gen #(.FETCH_WIDTH(FW), .NUM_REDIR(NR), .RESET_PC(RPC), .BTB_ENTRIES(BTBN)) dut (
    .clk(clk), .resetn(resetn), .preif_wr(preif_wr),
    .redir_valid(redir_valid), .redir_target(redir_target),
    .req_valid(req_valid), .req_pc(req_pc), .req_mask(req_mask), .req_ready(req_ready),
    .exc_adel(exc_adel), .pred_taken(pred_taken),
    .bu_valid(bu_valid), .bu_pc(bu_pc), .bu_target(bu_target)
  );

  always #5 clk = ~clk;

  function automatic int bidx(logic [31:0] pc);
    return int'((pc / 32'(4 * FW)) % 32'(BTBN));
  endfunction

  function automatic logic [31:0] btag(logic [31:0] pc);
    return pc / 32'(4 * FW * BTBN);
  endfunction

  function automatic bit m_hit(logic [31:0] pc);
    return BTB_EN && m_bv[bidx(pc)] && (m_btag[bidx(pc)] == btag(pc));
  endfunction

  task automatic model_reset();
    m_pc = RPC; m_mode = 0; m_pv = 0; m_pidx = 0; m_ptgt = 32'h0;
    for (int i = 0; i < BTBN; i++) m_bv[i] = 0;
  endtask

  task automatic model_update();
    bit          found, live;
    int          li;
    logic [31:0] tgt, ltgt;
    bit          hit;
    logic [31:0] htgt;
    if (!resetn) begin
      model_reset();
      return;
    end
    hit = m_hit(m_pc);
    htgt = m_btgt[bidx(m_pc)];
    found = 0; live = 0; li = 0; tgt = 32'h0; ltgt = 32'h0;
    for (int i = 0; i < NR; i++) begin
      if (!live && redir_valid[i]) begin live = 1; li = i; ltgt = redir_target[32*i +: 32]; end
      if (!found && redir_valid[i]) begin found = 1; tgt = redir_target[32*i +: 32]; end
      else if (!found && m_pv && m_pidx == i) begin found = 1; tgt = m_ptgt; end
    end
    if (preif_wr) begin
      if (found) begin
        m_pc = tgt; m_pv = 0; m_mode = 1;
      end else if (m_mode == 0) begin
        m_mode = 1;
      end else if (m_mode == 1) begin
        if (m_pc[1:0] != 2'b00) m_mode = 2;
        else if (req_ready) m_pc = hit ? htgt : (m_pc - (m_pc % 32'(4 * FW)) + 32'(4 * FW));
      end
    end else begin
      if (m_mode == 0) m_mode = 1;
      if (live && (!m_pv || li <= m_pidx)) begin m_pv = 1; m_pidx = li; m_ptgt = ltgt; end
    end
    if (BTB_EN && bu_valid) begin
      m_bv[bidx(bu_pc)] = 1; m_btag[bidx(bu_pc)] = btag(bu_pc); m_btgt[bidx(bu_pc)] = bu_target;
    end
  endtask

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_model();
    bit            mv;
    logic [FW-1:0] em;
    int            slot;
    mv   = (m_mode == 1) && (m_pc[1:0] == 2'b00);
    slot = int'((m_pc / 32'd4) % 32'(FW));
    for (int k = 0; k < FW; k++) em[k] = mv && (k >= slot);
    chk("m_req_valid", 32'(req_valid), 32'(mv));
    chk("m_req_pc", req_pc, m_pc);
    chk("m_req_mask", 32'(req_mask), 32'(em));
    chk("m_exc_adel", 32'(exc_adel), 32'((m_mode == 1) && (m_pc[1:0] != 2'b00)));
    chk("m_pred_taken", 32'(pred_taken), 32'(mv && m_hit(m_pc)));
  endtask

  task automatic step();
    check_model();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic redir(int ch, logic [31:0] t);
    redir_valid[ch] = 1'b1;
    redir_target[32*ch +: 32] = t;
  endtask

  function automatic logic [31:0] rand_tgt();
    int r;
    r = int'($urandom_range(0, 15));
    if (r == 0) return 32'hFFFFFFF8;
    if (r == 1) return 32'h80000002 + 32'($urandom_range(0, 63)) * 32'd4;
    return 32'h80000000 + 32'($urandom_range(0, 63)) * 32'd4;
  endfunction

  initial begin
    clk = 0; resetn = 0; preif_wr = 0; req_ready = 0; bu_valid = 0;
    redir_valid = '0; redir_target = '0; bu_pc = 32'h0; bu_target = 32'h0;
    @(posedge clk); @(posedge clk);
    model_reset();
    #1;
    chk("rst_valid", 32'(req_valid), 32'd0);
    chk("rst_pc", req_pc, 32'hBFC00000);
    chk("rst_mask", 32'(req_mask), 32'd0);
    chk("rst_adel", 32'(exc_adel), 32'd0);
    chk("rst_pred", 32'(pred_taken), 32'd0);

    // Boot gap then sequential groups
    resetn = 1; preif_wr = 1; req_ready = 1;
    step(); chk("seq0_pc", req_pc, 32'hBFC00000); chk("seq0_mask", 32'(req_mask), 32'd3);
    chk("seq0_valid", 32'(req_valid), 32'd1);
    step(); chk("seq1_pc", req_pc, 32'hBFC00008); chk("seq1_mask", 32'(req_mask), 32'd3);
    step(); chk("seq2_pc", req_pc, 32'hBFC00010); chk("seq2_mask", 32'(req_mask), 32'd3);

    // Redirect into mid-group
    redir(3, 32'h80001004);
    step(); redir_valid = '0;
    chk("ch3_pc", req_pc, 32'h80001004); chk("ch3_mask", 32'(req_mask), 32'd2);
    step(); chk("ch3_next", req_pc, 32'h80001008);

    // Redirects during a stall are held; higher priority replaces
    preif_wr = 0; redir(4, 32'h00000100);
    step(); redir_valid = '0; redir(1, 32'h00000200);
    step(); redir_valid = '0;
    chk("stall_pc", req_pc, 32'h80001008); chk("stall_valid", 32'(req_valid), 32'd1);
    preif_wr = 1;
    step(); chk("pend_pc", req_pc, 32'h00000200);
    step(); chk("pend_clr", req_pc, 32'h00000208);

    // Same-cycle priority
    redir(0, 32'hBFC00380); redir(2, 32'h00000400);
    step(); redir_valid = '0;
    chk("prio_pc", req_pc, 32'hBFC00380);

    // 32-bit wrap
    redir(5, 32'hFFFFFFF8);
    step(); redir_valid = '0;
    chk("wrap0", req_pc, 32'hFFFFFFF8);
    step(); chk("wrap1", req_pc, 32'h00000000);

    // Misaligned PC -> AdEL, HALT, recovery by redirect
    redir(2, 32'h80000002);
    step(); redir_valid = '0;
    chk("adel_flag", 32'(exc_adel), 32'd1); chk("adel_valid", 32'(req_valid), 32'd0);
    step(); chk("halt_adel", 32'(exc_adel), 32'd0); chk("halt_valid", 32'(req_valid), 32'd0);
    step(); chk("halt_pc", req_pc, 32'h80000002);
    redir(1, 32'h80000180);
    step(); redir_valid = '0;
    chk("recov_pc", req_pc, 32'h80000180); chk("recov_valid", 32'(req_valid), 32'd1);

    // BTB update then fetch of the same group
    bu_valid = 1; bu_pc = 32'h80000010; bu_target = 32'h80000100; redir(0, 32'h80000010);
    step(); bu_valid = 0; redir_valid = '0;
    chk("btb_pred", 32'(pred_taken), 32'(BTB_EN));
    step(); chk("btb_next", req_pc, BTB_EN ? 32'h80000100 : 32'h80000018);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      resetn    = ($urandom_range(0, 199) != 0);
      preif_wr  = ($urandom_range(0, 3) != 0);
      req_ready = ($urandom_range(0, 1) != 0);
      redir_valid = ($urandom_range(0, 3) == 0) ? NR'($urandom & $urandom) : '0;
      for (int c = 0; c < NR; c++) redir_target[32*c +: 32] = rand_tgt();
      bu_valid  = ($urandom_range(0, 3) == 0);
      bu_pc     = 32'h80000000 + 32'($urandom_range(0, 63)) * 32'd4;
      bu_target = rand_tgt();
      step();
    end
    check_model();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
